// File: rtl/dmem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bridge_pkg
// Description : Shared definitions for the data-memory bridge. Contains the
//               access-size encodings, the bridge FSM states, the default
//               address-map constants shared with the CPU address map, and the
//               byte-enable helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_bridge_pkg;

    // Access-size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Default address map (also consumed by the CPU address decoder)
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_ADDR = 32'hFFFF_0010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Little-endian byte enables for an access of the given size at the
    // given byte offset within the word.
    function automatic logic [3:0] lane_be(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : DEPTH_WORDS x 32 single-port synchronous RAM with four byte
//               write enables. Stored as four independent byte lanes so each
//               lane is written by exactly one process.
// Ports       : clk   - clock
//               en    - access enable (read or write this edge)
//               we    - 1 = write addressed lanes, 0 = read word
//               be    - per-lane write enables
//               addr  - word index
//               wdata - write data (lane i in [8i+7:8i])
//               rdata - registered read data, held until the next read
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rdata_q;

        // RAM array carries no reset; contents survive rst_n.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[i]) begin
                        mem[addr] <= wdata[8*i +: 8];
                    end
                end else begin
                    rdata_q <= mem[addr];
                end
            end
        end

        assign rdata[8*i +: 8] = rdata_q;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bridge
// Description : Bridge between the CPU load/store port and a byte-enabled data
//               RAM. Translates BASE_ADDR-relative addresses to word indices,
//               performs byte/half/word accesses with sign/zero extension,
//               inserts WAIT_STATES wait cycles and flags range, alignment and
//               size errors. Optional display register enabled by the
//               SEG_MMIO_EN macro.
// Ports       : clk, rst_n (async, active low)
//               req_valid/req_ready handshake; req_we, req_size, req_signed,
//               req_addr, req_wdata request fields
//               rsp_valid (1-cycle pulse), rsp_rdata, rsp_err
//               busy      - request in flight (WAIT or ACCESS)
//               seg_data  - display register (SEG_MMIO_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned WAIT_STATES = 0
`ifdef SEG_MMIO_EN
    , parameter logic [31:0] MMIO_ADDR = DEF_MMIO_ADDR
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
`ifdef SEG_MMIO_EN
    , output logic [31:0] seg_data
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned OW = AW + 2;    // byte-offset width inside the RAM window
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [OW-1:0] off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          we_q, we_d;
    logic          signed_q, signed_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          mmio_q, mmio_d;

    logic [31:0]   w_off;
    logic          w_req_err;
    logic          w_mmio;
    logic          w_accept;
    logic [31:0]   w_bank_wdata;
    logic [31:0]   w_bank_rdata;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign req_ready = (state_q == IDLE) || (state_q == RESP);
    assign busy      = (state_q == WAIT) || (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign w_accept  = req_valid && req_ready;

`ifdef SEG_MMIO_EN
    assign w_mmio = (req_addr == MMIO_ADDR);
`else
    assign w_mmio = 1'b0;
`endif

    // Request decode. The subtraction wraps, so addresses below BASE_ADDR
    // land far above the window and fall into the range check.
    always_comb begin
        w_off     = req_addr - BASE_ADDR;
        w_req_err = 1'b0;
        if (w_mmio) begin
            w_req_err = (req_size != SZ_WORD);
        end else begin
            if ((w_off >> OW) != 32'd0)                     w_req_err = 1'b1;
            if (req_size == SZ_ILL)                         w_req_err = 1'b1;
            if (req_size == SZ_HALF && w_off[0])            w_req_err = 1'b1;
            if (req_size == SZ_WORD && w_off[1:0] != 2'b00) w_req_err = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        size_d   = size_q;
        we_d     = we_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        mmio_d   = mmio_q;

        case (state_q)
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A new request may be taken in IDLE or in the RESP cycle, which
        // gives back-to-back throughput of one per WAIT_STATES+2 cycles.
        if (w_accept) begin
            off_d    = w_off[OW-1:0];
            size_d   = req_size;
            we_d     = req_we;
            signed_d = req_signed;
            wdata_d  = req_wdata;
            err_d    = w_req_err;
            mmio_d   = w_mmio;
            cnt_d    = WAIT_INIT;
            if (w_req_err)            state_d = RESP;
            else if (WAIT_STATES > 0) state_d = WAIT;
            else                      state_d = ACCESS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            off_q    <= '0;
            size_q   <= SZ_BYTE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            mmio_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            size_q   <= size_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            mmio_q   <= mmio_d;
        end
    end

    // Right-aligned store data replicated onto every lane; the byte enables
    // pick which lanes actually land in the RAM.
    always_comb begin
        case (size_q)
            SZ_BYTE: w_bank_wdata = {4{wdata_q[7:0]}};
            SZ_HALF: w_bank_wdata = {2{wdata_q[15:0]}};
            default: w_bank_wdata = wdata_q;
        endcase
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .en    ((state_q == ACCESS) && !mmio_q),
        .we    (we_q),
        .be    (lane_be(size_q, off_q[1:0])),
        .addr  (off_q[OW-1:2]),
        .wdata (w_bank_wdata),
        .rdata (w_bank_rdata)
    );

`ifdef SEG_MMIO_EN
    logic [31:0] seg_q, seg_d;

    always_comb begin
        seg_d = seg_q;
        if ((state_q == ACCESS) && mmio_q && we_q) seg_d = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_q <= '0;
        else        seg_q <= seg_d;
    end

    assign seg_data = seg_q;
`endif

    // Load-data extraction and extension, driven only in RESP of a good load
    always_comb begin
        w_word = w_bank_rdata;
`ifdef SEG_MMIO_EN
        if (mmio_q) w_word = seg_q;
`endif
        w_byte    = w_word[{off_q[1:0], 3'b000} +: 8];
        w_half    = off_q[1] ? w_word[31:16] : w_word[15:0];
        rsp_rdata = '0;
        if ((state_q == RESP) && !err_q && !we_q) begin
            case (size_q)
                SZ_BYTE: rsp_rdata = signed_q ? {{24{w_byte[7]}}, w_byte}  : {24'd0, w_byte};
                SZ_HALF: rsp_rdata = signed_q ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
                default: rsp_rdata = w_word;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bridge
// Description : Self-checking bench for dmem_bridge. Two instances: index 0
//               with WAIT_STATES=0, index 1 with WAIT_STATES=3. Expected
//               responses (data, error, capture edge) are queued on accept
//               and popped when rsp_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] data;
    } stim_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          edge_no;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [1:0]  req_size   [2];
    logic        req_signed [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];
    logic        busy       [2];
`ifdef SEG_MMIO_EN
    logic [31:0] seg_data   [2];
`endif

    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    stim_t stim_q[$];
    exp_t  sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_bridge #(.WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
`ifdef SEG_MMIO_EN
        , .seg_data(seg_data[0])
`endif
    );

    dmem_bridge #(.WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
`ifdef SEG_MMIO_EN
        , .seg_data(seg_data[1])
`endif
    );

    task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] data);
        stim_t s;
        s.we = we; s.size = size; s.sgn = sgn; s.addr = addr;
        s.wdata = wdata; s.err = err; s.data = data;
        stim_q.push_back(s);
    endtask

    // Presents queued requests back to back on instance d and scores every
    // response against the queued expectation, including its capture edge.
    task automatic run_reqs(input int d);
        int    guard = 0;
        int    ws    = (d == 0) ? WS0 : WS1;
        bit    have  = 1'b0;
        stim_t cur;
        exp_t  e;
        while ((have || stim_q.size() > 0 || sb_q.size() > 0) && guard < 300) begin
            @(negedge clk);
            guard++;
            if (rsp_valid[d] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_rsp dut%0d: rsp_valid=1 required 0 at edge %0d", d, cyc + 1);
                end else begin
                    e = sb_q.pop_front();
                    total++;
                    if (rsp_err[d] !== e.err) begin
                        bad++;
                        $display("FAIL rsp_err dut%0d: got %b required %b", d, rsp_err[d], e.err);
                    end
                    total++;
                    if (rsp_rdata[d] !== e.data) begin
                        bad++;
                        $display("FAIL rsp_rdata dut%0d: got %h required %h", d, rsp_rdata[d], e.data);
                    end
                    total++;
                    if (cyc + 1 != e.edge_no) begin
                        bad++;
                        $display("FAIL rsp_latency dut%0d: got edge %0d required edge %0d", d, cyc + 1, e.edge_no);
                    end
                end
            end
            if (!have && stim_q.size() > 0) begin
                cur  = stim_q.pop_front();
                have = 1'b1;
            end
            if (have) begin
                req_we[d]     = cur.we;
                req_size[d]   = cur.size;
                req_signed[d] = cur.sgn;
                req_addr[d]   = cur.addr;
                req_wdata[d]  = cur.wdata;
                req_valid[d]  = 1'b1;
                if (req_ready[d] === 1'b1) begin
                    e.err     = cur.err;
                    e.data    = cur.data;
                    e.edge_no = cyc + 1 + (cur.err ? 1 : ws + 2);
                    sb_q.push_back(e);
                    have = 1'b0;
                end
            end else begin
                req_valid[d] = 1'b0;
            end
        end
        req_valid[d] = 1'b0;
        if (guard >= 300) begin
            total++; bad++;
            $display("FAIL timeout dut%0d: %0d responses outstanding, required 0", d, sb_q.size());
            sb_q.delete();
            stim_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_ready dut%0d: got %b required 1", d, req_ready[d]); end
            total++;
            if (rsp_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid dut%0d: got %b required 0", d, rsp_valid[d]); end
            total++;
            if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b required 0", d, busy[d]); end
            total++;
            if (rsp_rdata[d] !== 32'h0) begin bad++; $display("FAIL reset_rdata dut%0d: got %h required 0", d, rsp_rdata[d]); end
`ifdef SEG_MMIO_EN
            total++;
            if (seg_data[d] !== 32'h0) begin bad++; $display("FAIL reset_seg dut%0d: got %h required 0", d, seg_data[d]); end
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Asynchronous reset in the middle of a cycle while a store is in flight
        @(negedge clk);
        req_we[1] = 1'b1; req_size[1] = SZ_WORD; req_signed[1] = 1'b0;
        req_addr[1] = 32'h1001_0010; req_wdata[1] = 32'h0000_0001;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL inflight_busy dut1: got %b required 1", busy[1]); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy[1] !== 1'b0) begin bad++; $display("FAIL async_busy dut1: got %b required 0", busy[1]); end
        total++;
        if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL async_ready dut1: got %b required 1", req_ready[1]); end
        total++;
        if (rsp_valid[1] !== 1'b0) begin bad++; $display("FAIL async_rsp_valid dut1: got %b required 0", rsp_valid[1]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word(input int d);
        add(1'b1, SZ_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'hDEAD_BEEF);
        run_reqs(d);
    endtask

    task automatic test_byte(input int d);
        add(1'b1, SZ_BYTE, 1'b0, 32'h1001_0005, 32'h1234_5680, 1'b0, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'hDEAD_80EF);
        add(1'b0, SZ_BYTE, 1'b1, 32'h1001_0005, 32'h0,         1'b0, 32'hFFFF_FF80);
        add(1'b0, SZ_BYTE, 1'b0, 32'h1001_0005, 32'h0,         1'b0, 32'h0000_0080);
        add(1'b0, SZ_BYTE, 1'b1, 32'h1001_0004, 32'h0,         1'b0, 32'hFFFF_FFEF);
        run_reqs(d);
    endtask

    task automatic test_half(input int d);
        add(1'b1, SZ_HALF, 1'b0, 32'h1001_0006, 32'hABCD_1234, 1'b0, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'h1234_80EF);
        add(1'b0, SZ_HALF, 1'b0, 32'h1001_0006, 32'h0,         1'b0, 32'h0000_1234);
        add(1'b0, SZ_HALF, 1'b1, 32'h1001_0004, 32'h0,         1'b0, 32'hFFFF_80EF);
        add(1'b1, SZ_HALF, 1'b1, 32'h1001_0003, 32'h0000_5555, 1'b1, 32'h0);
        add(1'b0, SZ_HALF, 1'b1, 32'h1001_0003, 32'h0,         1'b1, 32'h0);
        add(1'b0, SZ_ILL,  1'b0, 32'h1001_0004, 32'h0,         1'b1, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'h1234_80EF);
        add(1'b0, SZ_BYTE, 1'b0, 32'h1001_0007, 32'h0,         1'b0, 32'h0000_0012);
        run_reqs(d);
    endtask

    task automatic test_range(input int d);
        add(1'b0, SZ_WORD, 1'b0, 32'h1000_FFFC, 32'h0,         1'b1, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_0200, 32'h0,         1'b1, 32'h0);
        add(1'b1, SZ_WORD, 1'b0, 32'h1001_01FC, 32'hCAFE_F00D, 1'b0, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_01FC, 32'h0,         1'b0, 32'hCAFE_F00D);
        add(1'b1, SZ_WORD, 1'b0, 32'h1001_0200, 32'h1111_1111, 1'b1, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_0006, 32'h0,         1'b1, 32'h0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h1001_01FF, 32'h0,         1'b0, 32'h0000_00CA);
        run_reqs(d);
    endtask

    task automatic test_mmio(input int d);
`ifdef SEG_MMIO_EN
        add(1'b1, SZ_WORD, 1'b0, 32'hFFFF_0010, 32'h0000_1234, 1'b0, 32'h0);
        run_reqs(d);
        total++;
        if (seg_data[d] !== 32'h0000_1234) begin bad++; $display("FAIL seg_write dut%0d: got %h required 00001234", d, seg_data[d]); end
        add(1'b0, SZ_WORD, 1'b0, 32'hFFFF_0010, 32'h0,         1'b0, 32'h0000_1234);
        add(1'b1, SZ_BYTE, 1'b0, 32'hFFFF_0010, 32'h0000_00AA, 1'b1, 32'h0);
        add(1'b0, SZ_HALF, 1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0);
        run_reqs(d);
        total++;
        if (seg_data[d] !== 32'h0000_1234) begin bad++; $display("FAIL seg_hold dut%0d: got %h required 00001234", d, seg_data[d]); end
`else
        add(1'b1, SZ_WORD, 1'b0, 32'hFFFF_0010, 32'h0000_1234, 1'b1, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0);
        run_reqs(d);
`endif
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++)
                add(1'b1, SZ_WORD, 1'b0, 32'h1001_0020 + 32'(4 * i), 32'h0A0B_0C00 + 32'(i), 1'b0, 32'h0);
            add(1'b0, SZ_WORD, 1'b0, 32'h1001_0021, 32'h0, 1'b1, 32'h0);
            for (int i = 0; i < 4; i++)
                add(1'b0, SZ_WORD, 1'b0, 32'h1001_0020 + 32'(4 * i), 32'h0, 1'b0, 32'h0A0B_0C00 + 32'(i));
            run_reqs(d);
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        add(1'b1, SZ_WORD, 1'b0, 32'h1001_0008, 32'hA5A5_0001, 1'b0, 32'h0);
        run_reqs(1);
        @(negedge clk);
        req_we[1] = 1'b1; req_size[1] = SZ_WORD; req_signed[1] = 1'b0;
        req_addr[1] = 32'h1001_0008; req_wdata[1] = 32'h0000_0055;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL abort_busy dut1: got %b required 1", busy[1]); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (rsp_valid[1] !== 1'b0) begin bad++; $display("FAIL abort_rsp dut1: got %b required 0", rsp_valid[1]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[1] === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL abort_pulses dut1: got %0d required 0", pulses); end
        add(1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'hA5A5_0001);
        run_reqs(1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = SZ_WORD;
            req_signed[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
        end
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_word(d);
            test_byte(d);
            test_half(d);
            test_range(d);
            test_mmio(d);
        end
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
